// File: rtl/gba_eeprom_host.sv
// Bit-serial initiator for the GBA 1-bit EEPROM protocol: one 64-bit block read or write per command.
// Optional write busy-poll timeout is enabled by defining GBA_EEPROM_TIMEOUT_EN (bounded by POLL_MAX).
module gba_eeprom_host #(
  parameter int POLL_MAX = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_wide,
  input  logic [13:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        ee_cs,
  output logic        ee_valid,
  output logic        ee_write,
  output logic        ee_din,
  input  logic        ee_ready,
  input  logic        ee_dout
);

  localparam int CW = ($clog2(POLL_MAX + 1) > 7) ? $clog2(POLL_MAX + 1) : 7;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_STOP, S_RHEAD, S_RDATA, S_POLL, S_DONE
  } state_t;

  state_t         state_reg, state_next;
  logic           gap_reg, gap_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           write_reg, write_next;
  logic           wide_reg, wide_next;
  logic [13:0]    addr_reg, addr_next;
  logic [63:0]    wdata_reg, wdata_next;
  logic [63:0]    shift_reg, shift_next;
  logic [63:0]    rdata_reg, rdata_next;
  logic           hit_reg, hit_next;
  logic [CW-1:0]  phase_len;
  logic           beat;
`ifdef GBA_EEPROM_TIMEOUT_EN
  logic           timeout_reg, timeout_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      gap_reg   <= 1'b0;
      cnt_reg   <= '0;
      write_reg <= 1'b0;
      wide_reg  <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      shift_reg <= '0;
      rdata_reg <= '0;
      hit_reg   <= 1'b0;
`ifdef GBA_EEPROM_TIMEOUT_EN
      timeout_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      gap_reg   <= gap_next;
      cnt_reg   <= cnt_next;
      write_reg <= write_next;
      wide_reg  <= wide_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      shift_reg <= shift_next;
      rdata_reg <= rdata_next;
      hit_reg   <= hit_next;
`ifdef GBA_EEPROM_TIMEOUT_EN
      timeout_reg <= timeout_next;
`endif
    end
  end

  always_comb begin
    phase_len = CW'(1);
    case (state_reg)
      S_CMD:   phase_len = CW'(2);
      S_ADDR:  phase_len = wide_reg ? CW'(14) : CW'(6);
      S_WDATA: phase_len = CW'(64);
      S_RHEAD: phase_len = CW'(4);
      S_RDATA: phase_len = CW'(64);
      default: phase_len = CW'(1);
    endcase
  end

  assign beat      = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign req_ready = (state_reg == S_IDLE);
  assign rsp_valid = (state_reg == S_DONE);
  assign rsp_rdata = rdata_reg;
  assign ee_cs     = beat;
  assign ee_valid  = beat && !gap_reg;
  assign ee_write  = (state_reg == S_CMD) || (state_reg == S_ADDR) ||
                     (state_reg == S_WDATA) || (state_reg == S_STOP);
`ifdef GBA_EEPROM_TIMEOUT_EN
  assign rsp_timeout = rsp_valid && timeout_reg;
`else
  assign rsp_timeout = 1'b0;
`endif

  // Address and write data are shifted left per beat so the outgoing bit is always the top bit.
  always_comb begin
    ee_din = 1'b0;
    case (state_reg)
      S_CMD:   ee_din = !cnt_reg[0] || !write_reg;
      S_ADDR:  ee_din = addr_reg[13];
      S_WDATA: ee_din = wdata_reg[63];
      default: ee_din = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    gap_next   = gap_reg;
    cnt_next   = cnt_reg;
    write_next = write_reg;
    wide_next  = wide_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    shift_next = shift_reg;
    rdata_next = rdata_reg;
    hit_next   = hit_reg;
`ifdef GBA_EEPROM_TIMEOUT_EN
    timeout_next = timeout_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          state_next = S_CMD;
          gap_next   = 1'b0;
          cnt_next   = '0;
          hit_next   = 1'b0;
          write_next = req_write;
          wide_next  = req_wide;
          addr_next  = req_wide ? req_addr : {req_addr[5:0], 8'h00};
          wdata_next = req_wdata;
`ifdef GBA_EEPROM_TIMEOUT_EN
          timeout_next = 1'b0;
`endif
        end
      end
      S_DONE: state_next = S_IDLE;
      default: begin
        if (!gap_reg) begin
          if (ee_ready) begin
            gap_next = 1'b1;
            cnt_next = cnt_reg + CW'(1);
            case (state_reg)
              S_ADDR:  addr_next  = {addr_reg[12:0], 1'b0};
              S_WDATA: wdata_next = {wdata_reg[62:0], 1'b0};
              S_RDATA: shift_next = {shift_reg[62:0], ee_dout};
              S_POLL:  hit_next   = ee_dout;
              default: ;
            endcase
          end
        end else begin
          // Phase transitions happen at the end of the idle gap so every phase starts with a fresh beat.
          gap_next = 1'b0;
          if (state_reg == S_POLL) begin
            if (hit_reg) begin
              state_next = S_DONE;
`ifdef GBA_EEPROM_TIMEOUT_EN
            end else if (cnt_reg == CW'(POLL_MAX)) begin
              state_next   = S_DONE;
              timeout_next = 1'b1;
`endif
            end
          end else if (cnt_reg == phase_len) begin
            cnt_next = '0;
            case (state_reg)
              S_CMD:   state_next = S_ADDR;
              S_ADDR:  state_next = write_reg ? S_WDATA : S_STOP;
              S_WDATA: state_next = S_STOP;
              S_STOP:  state_next = write_reg ? S_POLL : S_RHEAD;
              S_RHEAD: state_next = S_RDATA;
              S_RDATA: begin
                state_next = S_DONE;
                rdata_next = shift_reg;
              end
              default: state_next = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_gba_eeprom_host.sv
// Self-checking bench for gba_eeprom_host: directed and randomized block transfers against a protocol-level model.
module tb_gba_eeprom_host;

  localparam int PM = 8;

  logic        clk, rst;
  logic        req_valid, req_ready, req_write, req_wide;
  logic [13:0] req_addr;
  logic [63:0] req_wdata, rsp_rdata;
  logic        rsp_valid, rsp_timeout;
  logic        ee_cs, ee_valid, ee_write, ee_din, ee_ready, ee_dout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [63:0] last_rdata = '0;

  gba_eeprom_host #(.POLL_MAX(PM)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .ee_cs(ee_cs), .ee_valid(ee_valid), .ee_write(ee_write), .ee_din(ee_din),
    .ee_ready(ee_ready), .ee_dout(ee_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "_ee_cs"}, ee_cs, 0);
    chk({tag, "_ee_valid"}, ee_valid, 0);
    chk({tag, "_ee_write"}, ee_write, 0);
    chk({tag, "_ee_din"}, ee_din, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
  endtask

  // One block transfer. The expected beat stream is built from the protocol rules; the
  // responder answers read beats from resp_q and records every accepted beat.
  task automatic run_txn(input bit wr, input bit wide, input logic [13:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata_in,
                         input logic [3:0] head, input int busy, input bit stall,
                         input int pulse_at);
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];
    bit         resp_q[$];
    int  n, npoll, t0, ridx, first_cyc, mism;
    bit  exp_to, done, acc_prev, stalled_prev, rdy;
    logic [1:0] prev_bits;

    n = wide ? 14 : 6;
    exp_to = 1'b0;
    exp_q.push_back(2'b11);
    exp_q.push_back({1'b1, ~wr});
    for (int i = n - 1; i >= 0; i--) exp_q.push_back({1'b1, addr[i]});
    if (wr) for (int i = 63; i >= 0; i--) exp_q.push_back({1'b1, wdata[i]});
    exp_q.push_back(2'b10);
    if (!wr) begin
      for (int i = 3; i >= 0; i--) resp_q.push_back(head[i]);
      for (int i = 63; i >= 0; i--) resp_q.push_back(rdata_in[i]);
      for (int i = 0; i < 68; i++) exp_q.push_back(2'b00);
    end else begin
      npoll = busy + 1;
`ifdef GBA_EEPROM_TIMEOUT_EN
      if (busy >= PM) begin
        npoll  = PM;
        exp_to = 1'b1;
      end
`endif
      for (int i = 0; i < busy; i++) resp_q.push_back(1'b0);
      resp_q.push_back(1'b1);
      for (int i = 0; i < npoll; i++) exp_q.push_back(2'b00);
    end

    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_wide  = wide;
    req_addr  = addr;
    req_wdata = wdata;
    t0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = {$urandom, $urandom};

    ridx = 0; first_cyc = -1; done = 0; acc_prev = 0; stalled_prev = 0; prev_bits = 2'b00;
    for (int k = 0; k < 4000 && !done; k++) begin
      if (k == pulse_at) begin
        chk("req_ready_busy", req_ready, 0);
        req_valid = 1'b1;
        req_write = ~wr;
      end else begin
        req_valid = 1'b0;
      end
      if (acc_prev) chk("gap_after_beat", ee_valid, 0);
      if (stalled_prev) begin
        chk("stall_valid_held", ee_valid, 1);
        chk("stall_bits_held", {ee_write, ee_din}, prev_bits);
      end
      if (rsp_valid) begin
        done = 1;
        req_valid = 1'b0;
        chk("rsp_timeout", rsp_timeout, exp_to);
        chk("cs_low_at_rsp", ee_cs, 0);
        if (!wr) chk("rsp_rdata", rsp_rdata, rdata_in);
        else     chk("rsp_rdata_held", rsp_rdata, last_rdata);
        chk("beat_count", got_q.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
          if (exp_q[i][1] ? (got_q[i] !== exp_q[i]) : (got_q[i][1] !== 1'b0)) mism++;
        end
        chk("beat_stream_mismatches", mism, 0);
        if (!stall) begin
          chk("first_beat_cycle", first_cyc - t0, 1);
          chk("rsp_latency", cyc - t0, 2 * exp_q.size() + 1);
        end
      end else begin
        rdy = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        ee_ready = rdy;
        ee_dout  = (ee_valid && !ee_write && ridx < resp_q.size()) ? resp_q[ridx] : 1'b0;
        acc_prev     = ee_valid && rdy;
        stalled_prev = ee_valid && !rdy;
        prev_bits    = {ee_write, ee_din};
        if (acc_prev) begin
          if (first_cyc < 0) first_cyc = cyc;
          got_q.push_back({ee_write, ee_din});
          if (!ee_write) ridx++;
        end
        @(negedge clk);
      end
    end
    if (!done) chk("rsp_within_bound", 0, 1);
    @(negedge clk);
    chk("req_ready_after", req_ready, 1);
    chk("rsp_single_pulse", rsp_valid, 0);
    if (!wr) last_rdata = rdata_in;
    $display("txn wr=%0d wide=%0d addr=%0h beats=%0d timeout=%0d rdata=%0h", wr, wide, addr,
             got_q.size(), exp_to, rsp_rdata);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; req_valid = 0; req_write = 0; req_wide = 0; req_addr = '0; req_wdata = '0;
    ee_ready = 1'b1; ee_dout = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Narrow read: head all ones, fixed data pattern.
    run_txn(0, 0, 14'h2A, 64'h0, 64'h0123456789ABCDEF, 4'hF, 0, 0, -1);
    // Wide write at the top address, busy for three polls.
    run_txn(1, 1, 14'h3FFF, 64'h8000000000000001, 64'h0, 4'h0, 3, 0, -1);
    // Narrow write with random ee_ready stalls.
    run_txn(1, 0, 14'h15, 64'hDEADBEEFCAFEF00D, 64'h0, 4'h0, 2, 1, -1);
`ifdef GBA_EEPROM_TIMEOUT_EN
    run_txn(1, 0, 14'h07, 64'h5555AAAA5555AAAA, 64'h0, 4'h0, 1000, 0, -1);
`endif
    // Request pulsed mid-transaction must be ignored.
    run_txn(0, 1, 14'h1234, 64'h0, 64'hFEDCBA9876543210, 4'h5, 0, 0, 20);
    pulses = 0;
    repeat (100) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("no_extra_rsp", pulses, 0);

    for (int i = 0; i < 6; i++) begin
      run_txn($urandom_range(0, 1), $urandom_range(0, 1), 14'($urandom), {$urandom, $urandom},
              {$urandom, $urandom}, 4'($urandom), $urandom_range(0, 6), $urandom_range(0, 1), -1);
    end

    // Reset during the address phase aborts immediately.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_wide = 1'b0; req_addr = 14'h33;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_addr_cs", ee_cs, 1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("abort");
    last_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("no_rsp_after_abort", pulses, 0);
    run_txn(0, 0, 14'h33, 64'h0, 64'h0F1E2D3C4B5A6978, 4'hA, 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
